// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
//   RESET_PC_DEF / EXC_VECTOR_DEF : default reset and exception-entry addresses
//   fetch_state_t                 : fetch sequencer state (FETCH / HOLD)
//   pc_sel_t                      : next-PC source select code
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_ERET = 3'd4,
    SEL_EXC  = 3'd5
  } pc_sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection.
//   pc          : current fetch address
//   br_taken/br_offset, jump/jump_index, jr/jr_target : redirect requests
//   exc_req/eret_req : exception / return, already merged with pending flags
//   eret_target : return address (live epc or captured epc)
//   pc_plus4    : pc + 4 (wraps at 2^32)
//   next_pc     : selected next fetch address (EXC_VECTOR if target misaligned)
//   misaligned  : selected register-sourced target has nonzero low bits
module pc_target_calc
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] eret_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  pc_sel_t     sel;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc_plus4 = pc + 32'd4;
  // Offset is a word count; the top two bits fall off, which is the 32-bit wrap.
  assign br_target = pc_plus4 + {br_offset[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (exc_req)       sel = SEL_EXC;
    else if (eret_req) sel = SEL_ERET;
    else if (jr)       sel = SEL_JR;
    else if (jump)     sel = SEL_J;
    else if (br_taken) sel = SEL_BR;
  end

  always_comb begin
    misaligned = 1'b0;
    next_pc    = pc_plus4;
    case (sel)
      SEL_EXC:  next_pc = EXC_VECTOR;
      SEL_ERET: begin
        next_pc    = eret_target;
        misaligned = (eret_target[1:0] != 2'b00);
      end
      SEL_JR: begin
        next_pc    = jr_target;
        misaligned = (jr_target[1:0] != 2'b00);
      end
      SEL_J:    next_pc = j_target;
      SEL_BR:   next_pc = br_target;
      default:  next_pc = pc_plus4;
    endcase
    // Only register-sourced targets can be misaligned; they divert to the handler.
    if (misaligned) next_pc = EXC_VECTOR;
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter and fetch sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   stall         : hold PC, no fetch advance
//   imem_ack      : instruction word for pc_out returned
//   br_*, jump*, jr* : redirects, honoured only on the advance cycle
//   exc, eret, epc_in : exception / return; latched if not on an advance cycle
//   imem_req      : fetch request (high in FETCH)
//   pc_out        : current fetch address
//   pc_plus4      : pc_out + 4, link value
//   addr_err      : high during the advance cycle that diverts a misaligned target
//   state         : debug view of the fetch state
//
// Handshake: imem_req is held high in FETCH until a cycle where imem_ack is
// sampled high; that cycle consumes the fetch. If stall is also high the unit
// parks in HOLD with imem_req low and advances once stall drops.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         imem_ack,
  input  logic         br_taken,
  input  logic [31:0]  br_offset,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  input  logic         jr,
  input  logic [31:0]  jr_target,
  input  logic         exc,
  input  logic         eret,
  input  logic [31:0]  epc_in,
  output logic         imem_req,
  output logic [31:0]  pc_out,
  output logic [31:0]  pc_plus4,
  output logic         addr_err,
  output fetch_state_t state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic         exc_pend, eret_pend;
  logic [31:0]  epc_pend;
  logic         advance;
  logic         exc_req, eret_req;
  logic [31:0]  eret_target;
  logic [31:0]  next_pc;
  logic         misaligned;

  assign advance = !rst && !stall &&
                   (((state_q == FETCH) && imem_ack) || (state_q == HOLD));

  // A live eret carries the freshest epc; otherwise use the captured one.
  assign exc_req     = exc | exc_pend;
  assign eret_req    = eret | eret_pend;
  assign eret_target = eret ? epc_in : epc_pend;

  pc_target_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_calc (
    .pc          (pc_q),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jump        (jump),
    .jump_index  (jump_index),
    .jr          (jr),
    .jr_target   (jr_target),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .eret_target (eret_target),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    imem_req = !rst && (state_q == FETCH);
    if (advance) begin
      state_d = FETCH;
    end else if ((state_q == FETCH) && imem_ack && stall) begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      exc_pend  <= 1'b0;
      eret_pend <= 1'b0;
      epc_pend  <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        pc_q      <= next_pc;
        exc_pend  <= 1'b0;
        eret_pend <= 1'b0;
      end else begin
        if (exc) exc_pend <= 1'b1;
        if (eret) begin
          eret_pend <= 1'b1;
          epc_pend  <= epc_in;
        end
      end
    end
  end

  assign pc_out   = pc_q;
  assign addr_err = advance && misaligned;
  assign state    = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h0040_0004;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst, stall, imem_ack, br_taken, jump, jr, exc, eret;
  logic [31:0]  br_offset, jr_target, epc_in;
  logic [25:0]  jump_index;
  logic         imem_req, addr_err;
  logic [31:0]  pc_out, pc_plus4;
  fetch_state_t state;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .imem_ack   (imem_ack),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jump       (jump),
    .jump_index (jump_index),
    .jr         (jr),
    .jr_target  (jr_target),
    .exc        (exc),
    .eret       (eret),
    .epc_in     (epc_in),
    .imem_req   (imem_req),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .addr_err   (addr_err),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: current pc, whether a consumed fetch is parked
  // behind a stall, and sticky exception/return requests.
  logic [31:0] m_pc = RST_PC;
  bit          m_parked = 0;
  bit          m_pexc = 0, m_peret = 0;
  logic [31:0] m_pepc = '0;

  // Redirect inputs for the next cycle; cleared after each cycle.
  bit          g_bt, g_j, g_jr, g_ex, g_er;
  logic [31:0] g_bo, g_jt, g_ep;
  logic [25:0] g_ji;
  logic        last_addr_err;

  task automatic clear_redirects();
    g_bt = 0; g_j = 0; g_jr = 0; g_ex = 0; g_er = 0;
    g_bo = '0; g_jt = '0; g_ep = '0; g_ji = '0;
  endtask

  task automatic run(input bit r, input bit st, input bit ack);
    bit          adv, bad;
    logic [31:0] seq, tgt, t;
    @(negedge clk);
    rst = r; stall = st; imem_ack = ack;
    br_taken = g_bt; br_offset = g_bo; jump = g_j; jump_index = g_ji;
    jr = g_jr; jr_target = g_jt; exc = g_ex; eret = g_er; epc_in = g_ep;
    #1;
    seq = m_pc + 32'd4;
    adv = !r && !st && (m_parked || ack);
    bad = 0;
    tgt = seq;
    if (g_ex || m_pexc) tgt = EXC_PC;
    else if (g_er || m_peret) begin
      t = g_er ? g_ep : m_pepc;
      bad = (t % 4) != 0;
      tgt = bad ? EXC_PC : t;
    end else if (g_jr) begin
      bad = (g_jt % 4) != 0;
      tgt = bad ? EXC_PC : g_jt;
    end else if (g_j) tgt = (seq & 32'hF000_0000) | (32'(g_ji) * 4);
    else if (g_bt) tgt = seq + g_bo * 4;
    check("imem_req", {31'b0, imem_req}, {31'b0, !r && !m_parked});
    check("addr_err", {31'b0, addr_err}, {31'b0, adv && bad});
    check("pc_out",   pc_out, m_pc);
    check("pc_plus4", pc_plus4, seq);
    check("hold_state", {31'b0, state == HOLD}, {31'b0, m_parked});
    last_addr_err = addr_err;
    @(posedge clk);
    if (r) begin
      m_pc = RST_PC; m_parked = 0; m_pexc = 0; m_peret = 0; m_pepc = '0;
    end else if (adv) begin
      m_pc = tgt; m_parked = 0; m_pexc = 0; m_peret = 0;
    end else begin
      if (!m_parked && ack && st) m_parked = 1;
      if (g_ex) m_pexc = 1;
      if (g_er) begin m_peret = 1; m_pepc = g_ep; end
    end
    clear_redirects();
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] exp);
    #1;
    check(tag, pc_out, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_redirects();
    rst = 1; stall = 0; imem_ack = 0; br_taken = 0; br_offset = '0; jump = 0;
    jump_index = '0; jr = 0; jr_target = '0; exc = 0; eret = 0; epc_in = '0;

    // Reset and sequential fetch
    run(1, 0, 1); run(1, 0, 0);
    expect_pc("reset_pc", RST_PC);
    run(0, 0, 1); expect_pc("seq1", 32'h0040_0004);
    run(0, 0, 1); expect_pc("seq2", 32'h0040_0008);
    run(0, 0, 0); expect_pc("no_ack", 32'h0040_0008);
    run(0, 0, 1); run(0, 0, 1); expect_pc("seq4", 32'h0040_0010);

    // Branches: backward and forward
    g_bt = 1; g_bo = 32'hFFFF_FFFC; run(0, 0, 1); expect_pc("br_back", 32'h0040_0004);
    g_jr = 1; g_jt = 32'h0040_0010; run(0, 0, 1); expect_pc("jr_ret", 32'h0040_0010);
    g_bt = 1; g_bo = 32'h0000_0003; run(0, 0, 1); expect_pc("br_fwd", 32'h0040_0020);

    // Jump, then jump+jr with jr winning
    g_j = 1; g_ji = 26'h010_0040; run(0, 0, 1); expect_pc("jump", 32'h0040_0100);
    g_j = 1; g_ji = 26'h010_0040; g_jr = 1; g_jt = 32'h0040_0200;
    run(0, 0, 1); expect_pc("jr_over_j", 32'h0040_0200);

    // Pending exception, then eret
    g_ex = 1; run(0, 0, 0); run(0, 0, 0); run(0, 0, 0);
    expect_pc("exc_wait", 32'h0040_0200);
    run(0, 0, 1); expect_pc("exc_pend", EXC_PC);
    g_er = 1; g_ep = 32'h0040_0018; run(0, 0, 1); expect_pc("eret", 32'h0040_0018);

    // Stall hold
    run(0, 1, 1); run(0, 1, 0); run(0, 1, 1);
    #1 check("hold_req_low", {31'b0, imem_req}, 32'd0);
    expect_pc("hold_pc", 32'h0040_0018);
    run(0, 0, 0); expect_pc("hold_release", 32'h0040_001C);

    // Misaligned jr
    g_jr = 1; g_jt = 32'h0040_0202; run(0, 0, 1);
    check("addr_err_pulse", {31'b0, last_addr_err}, 32'd1);
    expect_pc("misalign_pc", EXC_PC);
    run(0, 0, 1);
    check("addr_err_clear", {31'b0, last_addr_err}, 32'd0);

    // Reset in HOLD with an eret pending clears the pending return
    run(0, 1, 1); g_er = 1; g_ep = 32'h0040_0040; run(0, 1, 0);
    run(1, 1, 0); expect_pc("rst_in_hold", RST_PC);
    run(0, 0, 1); expect_pc("pend_cleared", 32'h0040_0004);

    // Sequential wrap
    g_jr = 1; g_jt = 32'hFFFF_FFFC; run(0, 0, 1); expect_pc("to_top", 32'hFFFF_FFFC);
    run(0, 0, 1); expect_pc("wrap", 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      g_bt = ($urandom_range(0, 2) == 0);
      g_bo = $urandom();
      g_j  = ($urandom_range(0, 4) == 0);
      g_ji = 26'($urandom());
      g_jr = ($urandom_range(0, 4) == 0);
      g_jt = $urandom();
      if ($urandom_range(0, 3) != 0) g_jt[1:0] = 2'b00;
      g_ex = ($urandom_range(0, 15) == 0);
      g_er = ($urandom_range(0, 9) == 0);
      g_ep = $urandom();
      if ($urandom_range(0, 3) != 0) g_ep[1:0] = 2'b00;
      run($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
